// File: rtl/fft_result_serializer.sv
// rtl/fft_result_serializer.sv - snapshots FFT bins and streams them as a framed byte sequence to UART TX.
// Optional trailing modulo-256 checksum byte when FFT_SER_CHECKSUM_EN is defined.
module fft_result_serializer #(
    parameter int N_BINS = 64,
    parameter int DATA_W = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BINS*DATA_W-1:0] yreal_flat,
    input  logic [N_BINS*DATA_W-1:0] yimag_flat,
    input  logic                     dataReady,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     dropped
);

    localparam int BIN_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;

`ifdef FFT_SER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD} state_t;
`endif

    state_t                   state_q, state_d;
    logic [BIN_W-1:0]         bin_q, bin_d;
    logic [2:0]               byte_q, byte_d;
    logic [7:0]               tx_data_q, tx_data_d;
    logic [N_BINS*DATA_W-1:0] real_buf_q, real_buf_d;
    logic [N_BINS*DATA_W-1:0] imag_buf_q, imag_buf_d;
`ifdef FFT_SER_CHECKSUM_EN
    logic [7:0]               sum_q, sum_d;
`endif

    logic                     accept;
    logic                     last_payload;
    logic [BIN_W-1:0]         nxt_bin, pbin;
    logic [2:0]               nxt_byte, pbyte;
    logic signed [DATA_W-1:0] sel_re, sel_im;
    logic [23:0]              word;
    logic [7:0]               pay_byte;

    assign tx_valid = (state_q != S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx_data  = tx_data_q;
    assign dropped  = dataReady && (state_q != S_IDLE);

    // tx_data is registered, so the mux looks ahead to the byte that follows the one being accepted
    always_comb begin
        nxt_byte = (byte_q == 3'd5) ? 3'd0 : byte_q + 3'd1;
        nxt_bin  = (byte_q == 3'd5) ? BIN_W'(bin_q + 1'b1) : bin_q;
        pbin     = (state_q == S_PAYLOAD) ? nxt_bin : '0;
        pbyte    = (state_q == S_PAYLOAD) ? nxt_byte : 3'd0;
        sel_re   = real_buf_q[int'(pbin)*DATA_W +: DATA_W];
        sel_im   = imag_buf_q[int'(pbin)*DATA_W +: DATA_W];
        word     = (pbyte < 3'd3) ? 24'(sel_re) : 24'(sel_im);
        case (pbyte)
            3'd0, 3'd3: pay_byte = word[23:16];
            3'd1, 3'd4: pay_byte = word[15:8];
            default:    pay_byte = word[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        byte_d       = byte_q;
        tx_data_d    = tx_data_q;
        real_buf_d   = real_buf_q;
        imag_buf_d   = imag_buf_q;
        frame_done   = 1'b0;
        accept       = (state_q != S_IDLE) && tx_ready;
        last_payload = (state_q == S_PAYLOAD) && (bin_q == BIN_W'(N_BINS - 1)) && (byte_q == 3'd5);
`ifdef FFT_SER_CHECKSUM_EN
        sum_d        = accept ? sum_q + tx_data_q : sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dataReady) begin
                    real_buf_d = yreal_flat;
                    imag_buf_d = yimag_flat;
                    bin_d      = '0;
                    byte_d     = 3'd0;
                    tx_data_d  = 8'hA5;
                    state_d    = S_HDR0;
`ifdef FFT_SER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                end
            end
            S_HDR0: begin
                if (accept) begin
                    tx_data_d = 8'h5A;
                    state_d   = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    tx_data_d = pay_byte;
                    bin_d     = '0;
                    byte_d    = 3'd0;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    if (last_payload) begin
`ifdef FFT_SER_CHECKSUM_EN
                        tx_data_d  = sum_q + tx_data_q;
                        state_d    = S_CSUM;
`else
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        tx_data_d = pay_byte;
                        bin_d     = nxt_bin;
                        byte_d    = nxt_byte;
                    end
                end
            end
`ifdef FFT_SER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    frame_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            byte_q     <= 3'd0;
            tx_data_q  <= 8'd0;
            real_buf_q <= '0;
            imag_buf_q <= '0;
`ifdef FFT_SER_CHECKSUM_EN
            sum_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            byte_q     <= byte_d;
            tx_data_q  <= tx_data_d;
            real_buf_q <= real_buf_d;
            imag_buf_q <= imag_buf_d;
`ifdef FFT_SER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

endmodule

// File: tb/tb_fft_result_serializer.sv
// tb/tb_fft_result_serializer.sv - self-checking bench for fft_result_serializer.
module tb_fft_result_serializer;

    localparam int N_BINS = 64;
    localparam int DATA_W = 18;
`ifdef FFT_SER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif
    localparam int FRAME_LEN = 2 + 6 * N_BINS + CSUM;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N_BINS*DATA_W-1:0] yreal_flat, yimag_flat;
    logic                     dataReady, tx_ready;
    logic [7:0]               tx_data;
    logic                     tx_valid, busy, frame_done, dropped;

    always #5 clk = ~clk;

    fft_result_serializer #(.N_BINS(N_BINS), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .yreal_flat(yreal_flat), .yimag_flat(yimag_flat),
        .dataReady(dataReady), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .dropped(dropped)
    );

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] re_in [N_BINS];
    logic [DATA_W-1:0] im_in [N_BINS];
    logic [7:0]        exp_q [$];
    logic [7:0]        got_q [$];

    typedef struct {
        int          bin;
        logic [17:0] re;
        logic [17:0] im;
        logic [47:0] bytes6;
    } vec_t;
    vec_t vecs [3];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_bins();
        for (int k = 0; k < N_BINS; k++) begin
            yreal_flat[k*DATA_W +: DATA_W] = re_in[k];
            yimag_flat[k*DATA_W +: DATA_W] = im_in[k];
        end
    endtask

    task automatic clear_bins();
        for (int k = 0; k < N_BINS; k++) begin
            re_in[k] = '0;
            im_in[k] = '0;
        end
    endtask

    task automatic random_bins();
        for (int k = 0; k < N_BINS; k++) begin
            re_in[k] = DATA_W'($urandom);
            im_in[k] = DATA_W'($urandom);
        end
    endtask

    // Reference: sign-extend with integer arithmetic, emit 24-bit two's complement MSB first
    function automatic void push_comp(input logic [DATA_W-1:0] x);
        int v;
        v = int'(x);
        if (x[DATA_W-1]) v = v - (1 << DATA_W);
        for (int b = 2; b >= 0; b--) exp_q.push_back(8'((v >> (8 * b)) & 255));
    endfunction

    task automatic build_expected();
        int s;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int k = 0; k < N_BINS; k++) begin
            push_comp(re_in[k]);
            push_comp(im_in[k]);
        end
`ifdef FFT_SER_CHECKSUM_EN
        s = 0;
        foreach (exp_q[i]) s += int'(exp_q[i]);
        exp_q.push_back(8'(s % 256));
`endif
    endtask

    task automatic run_frame(input string tag, input int ready_pct, input int drop_at, input bit drop_last);
        int  stab_err, fd_err, drop_err, bubble, bad;
        bit  pending, mid_done;
        logic [7:0] prev_data;
        stab_err = 0; fd_err = 0; drop_err = 0; bubble = 0; bad = -1;
        pending = 0; mid_done = 0; prev_data = 8'h00;
        build_expected();
        got_q.delete();
        @(negedge clk);
        dataReady = 1'b1;
        tx_ready  = 1'b0;
        #1;
        check({tag, " busy_before_capture"}, 64'(busy), 64'd0);
        check({tag, " dropped_on_capture"}, 64'(dropped), 64'd0);
        @(negedge clk);
        dataReady = 1'b0;
        random_bins();
        drive_bins();
        for (int cyc = 0; cyc < 20000 && got_q.size() < FRAME_LEN; cyc++) begin
            if (cyc > 0) @(negedge clk);
            tx_ready  = ($urandom_range(99) < ready_pct);
            dataReady = 1'b0;
            if (!mid_done && got_q.size() == drop_at) begin
                dataReady = 1'b1;
                mid_done  = 1'b1;
            end
            if (drop_last && tx_ready && got_q.size() == FRAME_LEN - 1) dataReady = 1'b1;
            #1;
            if (tx_valid !== 1'b1) begin
                bubble++;
                break;
            end
            if (pending && tx_data !== prev_data) stab_err++;
            if (dropped !== dataReady) drop_err++;
            if (tx_ready) begin
                got_q.push_back(tx_data);
                pending = 1'b0;
                if (frame_done !== (got_q.size() == FRAME_LEN)) fd_err++;
            end else begin
                pending   = 1'b1;
                prev_data = tx_data;
                if (frame_done !== 1'b0) fd_err++;
            end
        end
        @(negedge clk);
        dataReady = 1'b0;
        tx_ready  = 1'b0;
        #1;
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " tx_valid_after"}, 64'(tx_valid), 64'd0);
        check({tag, " bubble_or_timeout"}, 64'(bubble), 64'd0);
        check({tag, " length"}, 64'(got_q.size()), 64'(FRAME_LEN));
        check({tag, " hold_while_stalled"}, 64'(stab_err), 64'd0);
        check({tag, " frame_done_timing"}, 64'(fd_err), 64'd0);
        check({tag, " dropped_pulses"}, 64'(drop_err), 64'd0);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s content: byte %0d got %02h expected %02h", tag, bad, got_q[bad], exp_q[bad]);
        end
    endtask

    initial begin
        logic [47:0] g;
        int off, s;
        vecs[0] = '{0,  18'h00001, 18'h3FFFF, 48'h000001_FFFFFF};
        vecs[1] = '{63, 18'h1FFFF, 18'h20000, 48'h01FFFF_FE0000};
        vecs[2] = '{10, 18'h12345, 18'h2ABCD, 48'h012345_FEABCD};

        rst = 1'b0; dataReady = 1'b0; tx_ready = 1'b0;
        clear_bins();
        drive_bins();
        #22;
        check("reset tx_data", 64'(tx_data), 64'd0);
        check("reset tx_valid", 64'(tx_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        check("reset dropped", 64'(dropped), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        clear_bins();
        drive_bins();
        run_frame("zeros", 100, -1, 1'b0);
        check("zeros hdr0", 64'(got_q[0]), 64'hA5);
        check("zeros hdr1", 64'(got_q[1]), 64'h5A);
`ifdef FFT_SER_CHECKSUM_EN
        check("zeros checksum", 64'(got_q[FRAME_LEN-1]), 64'hFF);
`endif

        for (int v = 0; v < 3; v++) begin
            clear_bins();
            re_in[vecs[v].bin] = vecs[v].re;
            im_in[vecs[v].bin] = vecs[v].im;
            drive_bins();
            run_frame($sformatf("vec%0d", v), 100, -1, 1'b0);
            off = 2 + 6 * vecs[v].bin;
            g = '0;
            for (int i = 0; i < 6; i++)
                if (off + i < got_q.size()) g = {g[39:0], got_q[off+i]};
            check($sformatf("vec%0d bin_bytes", v), 64'(g), 64'(vecs[v].bytes6));
`ifdef FFT_SER_CHECKSUM_EN
            s = 255;
            for (int i = 0; i < 6; i++) s += int'(vecs[v].bytes6[8*i +: 8]);
            check($sformatf("vec%0d checksum", v), 64'(got_q[got_q.size()-1]), 64'(s % 256));
`endif
        end

        for (int f = 0; f < 2; f++) begin
            random_bins();
            drive_bins();
            run_frame($sformatf("rand%0d", f), 50, -1, 1'b0);
        end

        random_bins();
        drive_bins();
        run_frame("drops", 50, 100, 1'b1);
        random_bins();
        drive_bins();
        run_frame("after_drops", 70, -1, 1'b0);

        random_bins();
        drive_bins();
        @(negedge clk);
        dataReady = 1'b1;
        @(negedge clk);
        dataReady = 1'b0;
        tx_ready  = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst tx_valid", 64'(tx_valid), 64'd0);
        check("async_rst busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        s = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (tx_valid !== 1'b0 || busy !== 1'b0) s++;
        end
        check("post_rst silent", 64'(s), 64'd0);
        random_bins();
        drive_bins();
        run_frame("post_rst", 60, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
